// File: rtl/example_bus_arbiter.sv
// ---------------------------------------------------------------------------
// example_bus_arbiter
//
// Arbitrates between instruction fetch and load/store requests for the single
// combined text/data memory bus of the multicycle RISC-V example. One access
// is granted at a time. Reads hold address/read_enable across the memory's
// one-cycle synchronous read latency, then the result is returned to the
// owning requester with a one-cycle valid pulse. Stores complete in the
// cycle they are accepted.
//
// Parameters:
//   FETCH_PRIORITY : 0 = round-robin on ties, 1 = fetch always wins ties
//
// Optional feature (macro EXAMPLE_BUS_ADDR_CHECK_EN):
//   Granted addresses are decoded against `TEXT_BEGIN..`TEXT_END and
//   `DATA_BEGIN..`DATA_END. Faulting accesses are accepted but never reach
//   the bus; the requester gets an error pulse instead. Without the macro
//   fetch_error/data_error are constant 0.
//
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   fetch_req/addr               : fetch request (held until fetch_ready)
//   fetch_ready/valid/data/error : fetch accept, read return, fault flag
//   data_req/we/addr/wdata/be    : load/store request (held until data_ready)
//   data_ready/valid/rdata/error : data accept, load return, fault flag
//   bus_*                        : shared memory bus (read data 1 cycle late)
// ---------------------------------------------------------------------------
`ifdef EXAMPLE_BUS_ADDR_CHECK_EN
`ifndef TEXT_BEGIN
`define TEXT_BEGIN 32'h0040_0000
`endif
`ifndef TEXT_END
`define TEXT_END   32'h0040_FFFF
`endif
`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h1001_0000
`endif
`ifndef DATA_END
`define DATA_END   32'h1001_FFFF
`endif
`endif

module example_bus_arbiter #(
  parameter bit FETCH_PRIORITY = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  output logic        fetch_error,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_ready,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        data_error,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic [31:0] bus_read_data
);

  typedef enum logic {IDLE, READ_WAIT} state_t;
  typedef enum logic {SRC_FETCH, SRC_DATA} src_t;

  state_t      state, state_next;
  src_t        last_grant, last_grant_next;
  src_t        owner, owner_next;
  logic [31:0] hold_addr, hold_addr_next;
  logic        hold_fault, hold_fault_next;
  logic        store_fault, store_fault_next;
  logic        fetch_fault, data_fault;
  logic        grant_fetch, grant_data;

  // Address decode: fetches must hit text, stores must hit data, loads may
  // hit either range.
`ifdef EXAMPLE_BUS_ADDR_CHECK_EN
  function automatic logic in_text(input logic [31:0] a);
    return (a >= `TEXT_BEGIN) && (a <= `TEXT_END);
  endfunction

  function automatic logic in_data(input logic [31:0] a);
    return (a >= `DATA_BEGIN) && (a <= `DATA_END);
  endfunction

  assign fetch_fault = !in_text(fetch_addr);
  assign data_fault  = data_we ? !in_data(data_addr)
                               : !(in_text(data_addr) || in_data(data_addr));
`else
  assign fetch_fault = 1'b0;
  assign data_fault  = 1'b0;
`endif

  // State register; reset abandons any read in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= SRC_DATA;
      owner       <= SRC_FETCH;
      hold_addr   <= '0;
      hold_fault  <= 1'b0;
      store_fault <= 1'b0;
    end else begin
      state       <= state_next;
      last_grant  <= last_grant_next;
      owner       <= owner_next;
      hold_addr   <= hold_addr_next;
      hold_fault  <= hold_fault_next;
      store_fault <= store_fault_next;
    end
  end

  // Grant selection, only possible in IDLE. On a tie the source that did not
  // win last time is chosen unless fetch has fixed priority.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (state == IDLE && !reset) begin
      if (fetch_req && data_req) begin
        if (FETCH_PRIORITY || last_grant == SRC_DATA) grant_fetch = 1'b1;
        else                                          grant_data  = 1'b1;
      end else begin
        grant_fetch = fetch_req;
        grant_data  = data_req;
      end
    end
  end

  // Next state and all outputs. Everything is forced to 0 while reset is
  // asserted so an abandoned read produces no valid pulse.
  always_comb begin
    state_next       = state;
    last_grant_next  = last_grant;
    owner_next       = owner;
    hold_addr_next   = hold_addr;
    hold_fault_next  = hold_fault;
    store_fault_next = 1'b0;
    fetch_ready      = 1'b0;
    fetch_valid      = 1'b0;
    fetch_data       = '0;
    fetch_error      = 1'b0;
    data_ready       = 1'b0;
    data_valid       = 1'b0;
    data_rdata       = '0;
    data_error       = 1'b0;
    bus_address      = '0;
    bus_write_data   = '0;
    bus_byte_enable  = '0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;

    if (!reset) begin
      // A store that faulted last cycle reports its error now.
      if (store_fault) begin
        data_valid = 1'b1;
        data_error = 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_fetch) begin
            fetch_ready     = 1'b1;
            bus_address     = fetch_addr;
            bus_byte_enable = 4'b1111;
            bus_read_enable = !fetch_fault;
            hold_addr_next  = fetch_addr;
            hold_fault_next = fetch_fault;
            owner_next      = SRC_FETCH;
            last_grant_next = SRC_FETCH;
            state_next      = READ_WAIT;
          end else if (grant_data) begin
            data_ready      = 1'b1;
            bus_address     = data_addr;
            last_grant_next = SRC_DATA;
            if (data_we) begin
              bus_write_data   = data_wdata;
              bus_byte_enable  = data_be;
              bus_write_enable = !data_fault;
              store_fault_next = data_fault;
            end else begin
              bus_byte_enable = 4'b1111;
              bus_read_enable = !data_fault;
              hold_addr_next  = data_addr;
              hold_fault_next = data_fault;
              owner_next      = SRC_DATA;
              state_next      = READ_WAIT;
            end
          end
        end

        READ_WAIT: begin
          // The memory read mux is address-decoded, so the address and
          // read enable must stay put while the data comes back.
          bus_address     = hold_addr;
          bus_byte_enable = 4'b1111;
          bus_read_enable = !hold_fault;
          if (owner == SRC_FETCH) begin
            fetch_valid = 1'b1;
            fetch_data  = hold_fault ? 32'h0 : bus_read_data;
            fetch_error = hold_fault;
          end else begin
            data_valid  = 1'b1;
            data_rdata  = hold_fault ? 32'h0 : bus_read_data;
            data_error  = hold_fault;
          end
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_example_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_example_bus_arbiter
//
// Self-checking bench for example_bus_arbiter. A round-robin instance (dut)
// is attached to a byte-enabled synchronous memory model; a fetch-priority
// instance (dut_p) is used for the tie-break scenario. Inputs are driven 1ns
// after the rising edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
`ifndef TEXT_BEGIN
`define TEXT_BEGIN 32'h0040_0000
`endif
`ifndef TEXT_END
`define TEXT_END   32'h0040_FFFF
`endif
`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h1001_0000
`endif
`ifndef DATA_END
`define DATA_END   32'h1001_FFFF
`endif

module tb_example_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req, data_req, data_we;
  logic [31:0] fetch_addr, data_addr, data_wdata;
  logic [3:0]  data_be;
  logic        fetch_ready, fetch_valid, fetch_error;
  logic [31:0] fetch_data;
  logic        data_ready, data_valid, data_error;
  logic [31:0] data_rdata;
  logic [31:0] bus_address, bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable, bus_write_enable;
  logic [31:0] bus_read_data = 32'h0;

  logic        p_fetch_req, p_data_req, p_data_we;
  logic [31:0] p_fetch_addr, p_data_addr, p_data_wdata;
  logic [3:0]  p_data_be;
  logic        p_fetch_ready, p_fetch_valid, p_fetch_error;
  logic [31:0] p_fetch_data;
  logic        p_data_ready, p_data_valid, p_data_error;
  logic [31:0] p_data_rdata;
  logic [31:0] p_bus_address, p_bus_write_data;
  logic [3:0]  p_bus_byte_enable;
  logic        p_bus_read_enable, p_bus_write_enable;
  logic [31:0] p_bus_read_data = 32'h0;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem     [bit [29:0]];
  logic [31:0] ref_mem [bit [29:0]];
  logic [31:0] wr_word;

  always #5 clock = ~clock;

  example_bus_arbiter #(.FETCH_PRIORITY(1'b0)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_error(fetch_error),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be), .data_ready(data_ready),
    .data_valid(data_valid), .data_rdata(data_rdata), .data_error(data_error),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
    .bus_write_enable(bus_write_enable), .bus_read_data(bus_read_data)
  );

  example_bus_arbiter #(.FETCH_PRIORITY(1'b1)) dut_p (
    .clock(clock), .reset(reset),
    .fetch_req(p_fetch_req), .fetch_addr(p_fetch_addr), .fetch_ready(p_fetch_ready),
    .fetch_valid(p_fetch_valid), .fetch_data(p_fetch_data), .fetch_error(p_fetch_error),
    .data_req(p_data_req), .data_we(p_data_we), .data_addr(p_data_addr),
    .data_wdata(p_data_wdata), .data_be(p_data_be), .data_ready(p_data_ready),
    .data_valid(p_data_valid), .data_rdata(p_data_rdata), .data_error(p_data_error),
    .bus_address(p_bus_address), .bus_write_data(p_bus_write_data),
    .bus_byte_enable(p_bus_byte_enable), .bus_read_enable(p_bus_read_enable),
    .bus_write_enable(p_bus_write_enable), .bus_read_data(p_bus_read_data)
  );

  // Synchronous memory: byte-enabled writes, registered read data.
  always @(posedge clock) begin
    if (bus_write_enable) begin
      wr_word = mem.exists(bus_address[31:2]) ? mem[bus_address[31:2]] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (bus_byte_enable[b]) wr_word[8*b +: 8] = bus_write_data[8*b +: 8];
      mem[bus_address[31:2]] = wr_word;
    end
    if (bus_read_enable)
      bus_read_data <= mem.exists(bus_address[31:2]) ? mem[bus_address[31:2]] : 32'h0;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
  endfunction

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    fetch_req = 0; fetch_addr = 0; data_req = 0; data_we = 0;
    data_addr = 0; data_wdata = 0; data_be = 0;
    p_fetch_req = 0; p_fetch_addr = 0; p_data_req = 0; p_data_we = 0;
    p_data_addr = 0; p_data_wdata = 0; p_data_be = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1;
    next_cycle();
    reset = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    fetch_req = 1; fetch_addr = `TEXT_BEGIN;
    data_req = 1; data_we = 1; data_addr = `DATA_BEGIN; data_wdata = 32'hA5A5_5A5A; data_be = 4'hF;
    @(negedge clock);
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_ready got=%0b exp=0", fetch_ready); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_ready got=%0b exp=0", data_ready); end
    checks++; if ({bus_read_enable, bus_write_enable} !== 2'b00) begin errors++; $display("[TB] FAIL reset_bus_en got=%b exp=00", {bus_read_enable, bus_write_enable}); end
    checks++; if ({bus_address, bus_write_data, bus_byte_enable} !== 68'h0) begin errors++; $display("[TB] FAIL reset_bus_fields addr=%h wdata=%h be=%b exp=0", bus_address, bus_write_data, bus_byte_enable); end
    checks++; if ({fetch_valid, data_valid, fetch_error, data_error} !== 4'b0) begin errors++; $display("[TB] FAIL reset_valid_error got=%b exp=0000", {fetch_valid, data_valid, fetch_error, data_error}); end
    next_cycle();
    reset = 0;
    clear_inputs();
    @(negedge clock);
    checks++; if ({bus_read_enable, bus_write_enable, bus_address} !== 34'h0) begin errors++; $display("[TB] FAIL idle_bus got=%b/%b/%h exp=0", bus_read_enable, bus_write_enable, bus_address); end
    next_cycle();
  endtask

  task automatic test_fetch;
    fetch_req = 1; fetch_addr = `TEXT_BEGIN + 32'h10;
    @(negedge clock);
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ready got=%0b exp=1", fetch_ready); end
    checks++; if (bus_read_enable !== 1'b1 || bus_address !== `TEXT_BEGIN + 32'h10) begin errors++; $display("[TB] FAIL fetch_bus_n re=%0b addr=%h exp 1/%h", bus_read_enable, bus_address, `TEXT_BEGIN + 32'h10); end
    checks++; if (bus_byte_enable !== 4'b1111) begin errors++; $display("[TB] FAIL fetch_be got=%b exp=1111", bus_byte_enable); end
    checks++; if (fetch_valid !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_early_valid got=%0b/%0b exp=0/0", fetch_valid, data_valid); end
    next_cycle();
    fetch_req = 0;
    @(negedge clock);
    checks++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h00A0_0093) begin errors++; $display("[TB] FAIL fetch_return valid=%0b data=%h exp 1/00a00093", fetch_valid, fetch_data); end
    checks++; if (bus_read_enable !== 1'b1 || bus_address !== `TEXT_BEGIN + 32'h10) begin errors++; $display("[TB] FAIL fetch_bus_hold re=%0b addr=%h", bus_read_enable, bus_address); end
    checks++; if (data_valid !== 1'b0 || fetch_ready !== 1'b0 || fetch_error !== 1'b0) begin errors++; $display("[TB] FAIL fetch_wait_misc dv=%0b fr=%0b fe=%0b exp 0", data_valid, fetch_ready, fetch_error); end
    next_cycle();
    @(negedge clock);
    checks++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h0 || bus_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL fetch_after fv=%0b fd=%h re=%0b exp 0", fetch_valid, fetch_data, bus_read_enable); end
    next_cycle();
  endtask

  task automatic test_store_load;
    data_req = 1; data_we = 1; data_addr = `DATA_BEGIN + 32'h4;
    data_wdata = 32'hDEAD_BEEF; data_be = 4'b0011;
    @(negedge clock);
    checks++; if (data_ready !== 1'b1 || bus_write_enable !== 1'b1 || bus_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL store_accept dr=%0b we=%0b re=%0b exp 1/1/0", data_ready, bus_write_enable, bus_read_enable); end
    checks++; if (bus_address !== `DATA_BEGIN + 32'h4 || bus_write_data !== 32'hDEAD_BEEF || bus_byte_enable !== 4'b0011) begin errors++; $display("[TB] FAIL store_bus addr=%h wd=%h be=%b", bus_address, bus_write_data, bus_byte_enable); end
    next_cycle();
    data_we = 0; data_wdata = 0; data_be = 0;
    @(negedge clock);
    checks++; if (bus_write_enable !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("[TB] FAIL store_pulse we=%0b dv=%0b exp 0/0", bus_write_enable, data_valid); end
    checks++; if (data_ready !== 1'b1 || bus_read_enable !== 1'b1) begin errors++; $display("[TB] FAIL load_accept dr=%0b re=%0b exp 1/1", data_ready, bus_read_enable); end
    next_cycle();
    data_req = 0;
    @(negedge clock);
    checks++; if (data_valid !== 1'b1 || data_rdata !== 32'h0000_BEEF) begin errors++; $display("[TB] FAIL load_return dv=%0b rd=%h exp 1/0000beef", data_valid, data_rdata); end
    next_cycle();
    @(negedge clock);
    checks++; if (data_valid !== 1'b0 || data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL load_single_pulse dv=%0b rd=%h exp 0", data_valid, data_rdata); end
    next_cycle();
  endtask

  task automatic test_tie;
    do_reset();
    fetch_req = 1; fetch_addr = `TEXT_BEGIN; data_req = 1; data_addr = `DATA_BEGIN + 32'h4;
    p_fetch_req = 1; p_fetch_addr = `TEXT_BEGIN; p_data_req = 1; p_data_addr = `DATA_BEGIN;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      // Round robin: F at 0, D at 2, F at 4; returns one cycle later.
      checks++; if (fetch_ready !== (i % 4 == 0) || data_ready !== (i % 4 == 2)) begin errors++; $display("[TB] FAIL tie_rr_ready i=%0d fr=%0b dr=%0b", i, fetch_ready, data_ready); end
      checks++; if (fetch_valid !== (i % 4 == 1) || data_valid !== (i % 4 == 3)) begin errors++; $display("[TB] FAIL tie_rr_valid i=%0d fv=%0b dv=%0b", i, fetch_valid, data_valid); end
      checks++; if (p_fetch_ready !== (i % 2 == 0) || p_data_ready !== 1'b0) begin errors++; $display("[TB] FAIL tie_prio_ready i=%0d fr=%0b dr=%0b", i, p_fetch_ready, p_data_ready); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_read_wait;
    do_reset();
    data_req = 1; data_addr = `DATA_BEGIN + 32'h4;
    @(negedge clock);
    checks++; if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL rrw_accept dr=%0b exp 1", data_ready); end
    next_cycle();
    data_req = 0; reset = 1;
    @(negedge clock);
    checks++; if (data_valid !== 1'b0 || bus_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL rrw_abandon dv=%0b re=%0b exp 0/0", data_valid, bus_read_enable); end
    next_cycle();
    reset = 0;
    @(negedge clock);
    checks++; if (data_valid !== 1'b0 || {bus_read_enable, bus_write_enable} !== 2'b00) begin errors++; $display("[TB] FAIL rrw_idle dv=%0b en=%b exp 0", data_valid, {bus_read_enable, bus_write_enable}); end
    next_cycle();
    fetch_req = 1; fetch_addr = `TEXT_BEGIN + 32'h10;
    @(negedge clock);
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL rrw_next_grant fr=%0b exp 1", fetch_ready); end
    next_cycle();
    fetch_req = 0;
    next_cycle();
  endtask

  task automatic test_wait_in_read;
    data_req = 1; data_we = 0; data_addr = `DATA_BEGIN + 32'h4;
    @(negedge clock);
    checks++; if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL wir_load dr=%0b exp 1", data_ready); end
    next_cycle();
    data_req = 0; fetch_req = 1; fetch_addr = `TEXT_BEGIN + 32'h8;
    @(negedge clock);
    checks++; if (fetch_ready !== 1'b0 || data_valid !== 1'b1) begin errors++; $display("[TB] FAIL wir_blocked fr=%0b dv=%0b exp 0/1", fetch_ready, data_valid); end
    next_cycle();
    @(negedge clock);
    checks++; if (fetch_ready !== 1'b1 || bus_address !== `TEXT_BEGIN + 32'h8) begin errors++; $display("[TB] FAIL wir_granted fr=%0b addr=%h exp 1/%h", fetch_ready, bus_address, `TEXT_BEGIN + 32'h8); end
    next_cycle();
    fetch_req = 0;
    next_cycle();
  endtask

`ifdef EXAMPLE_BUS_ADDR_CHECK_EN
  task automatic test_addr_check;
    do_reset();
    data_req = 1; data_we = 1; data_addr = `TEXT_BEGIN; data_wdata = 32'h1234_5678; data_be = 4'hF;
    @(negedge clock);
    checks++; if (data_ready !== 1'b1 || bus_write_enable !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("[TB] FAIL ac_store dr=%0b we=%0b dv=%0b exp 1/0/0", data_ready, bus_write_enable, data_valid); end
    next_cycle();
    data_we = 0; data_addr = 32'h0; data_wdata = 0;
    @(negedge clock);
    checks++; if (data_valid !== 1'b1 || data_error !== 1'b1) begin errors++; $display("[TB] FAIL ac_store_err dv=%0b de=%0b exp 1/1", data_valid, data_error); end
    checks++; if (data_ready !== 1'b1 || bus_read_enable !== 1'b0 || bus_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL ac_load_accept dr=%0b re=%0b we=%0b exp 1/0/0", data_ready, bus_read_enable, bus_write_enable); end
    next_cycle();
    data_req = 0;
    @(negedge clock);
    checks++; if (data_valid !== 1'b1 || data_error !== 1'b1 || data_rdata !== 32'h0 || bus_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL ac_load_err dv=%0b de=%0b rd=%h re=%0b", data_valid, data_error, data_rdata, bus_read_enable); end
    next_cycle();
    fetch_req = 1; fetch_addr = `DATA_BEGIN;
    @(negedge clock);
    checks++; if (fetch_ready !== 1'b1 || bus_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL ac_fetch_accept fr=%0b re=%0b exp 1/0", fetch_ready, bus_read_enable); end
    next_cycle();
    fetch_req = 0;
    @(negedge clock);
    checks++; if (fetch_valid !== 1'b1 || fetch_error !== 1'b1 || fetch_data !== 32'h0) begin errors++; $display("[TB] FAIL ac_fetch_err fv=%0b fe=%0b fd=%h", fetch_valid, fetch_error, fetch_data); end
    next_cycle();
    @(negedge clock);
    checks++; if (fetch_error !== 1'b0 || data_error !== 1'b0) begin errors++; $display("[TB] FAIL ac_err_clear fe=%0b de=%0b exp 0", fetch_error, data_error); end
    next_cycle();
  endtask
`endif

  // Random traffic against a transaction-level model: one grant per free
  // cycle, reads return one cycle later, stores take effect immediately.
  task automatic test_random;
    bit          f_pend, d_pend, d_st, busy, rd_to_data, last_data;
    logic [31:0] f_a, d_a, d_wd, rd_val, e_addr;
    logic [3:0]  d_b;
    logic        e_fr, e_dr, e_fv, e_dv, e_we, e_drive;
    logic [31:0] e_fd, e_dd;
    do_reset();
    for (int w = 0; w < 16; w++) mem[(`TEXT_BEGIN >> 2) + w] = $urandom;
    ref_mem = mem;
    f_pend = 0; d_pend = 0; busy = 0; rd_to_data = 0; last_data = 1; rd_val = 0;
    f_a = 0; d_a = 0; d_wd = 0; d_b = 0; d_st = 0;
    for (int c = 0; c < 300; c++) begin
      if (!f_pend && $urandom_range(0, 1) == 1) begin
        f_pend = 1;
        f_a = `TEXT_BEGIN + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1;
        d_st = $urandom_range(0, 1);
        d_a = `DATA_BEGIN + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
        d_wd = $urandom;
        d_b = 4'($urandom_range(0, 15));
      end
      fetch_req = f_pend; fetch_addr = f_pend ? f_a : 32'h0;
      data_req = d_pend; data_we = d_pend & d_st; data_addr = d_pend ? d_a : 32'h0;
      data_wdata = d_pend ? d_wd : 32'h0; data_be = d_pend ? d_b : 4'h0;

      e_fr = 0; e_dr = 0; e_fv = 0; e_dv = 0; e_fd = 0; e_dd = 0; e_we = 0; e_drive = 0; e_addr = 0;
      if (busy) begin
        if (rd_to_data) begin e_dv = 1; e_dd = rd_val; end
        else            begin e_fv = 1; e_fd = rd_val; end
        busy = 0;
      end else if (f_pend && (!d_pend || last_data)) begin
        e_fr = 1; e_drive = 1; e_addr = f_a;
        rd_val = ref_read(f_a); rd_to_data = 0; busy = 1; last_data = 0;
      end else if (d_pend) begin
        e_dr = 1; e_drive = 1; e_addr = d_a; last_data = 1;
        if (d_st) begin
          e_we = 1;
          rd_val = ref_read(d_a);
          for (int b = 0; b < 4; b++) if (d_b[b]) rd_val[8*b +: 8] = d_wd[8*b +: 8];
          ref_mem[d_a[31:2]] = rd_val;
        end else begin
          rd_val = ref_read(d_a); rd_to_data = 1; busy = 1;
        end
      end

      @(negedge clock);
      checks++; if (fetch_ready !== e_fr || data_ready !== e_dr) begin errors++; $display("[TB] FAIL rnd_ready c=%0d fr=%0b dr=%0b exp %0b/%0b", c, fetch_ready, data_ready, e_fr, e_dr); end
      checks++; if (fetch_valid !== e_fv || fetch_data !== e_fd) begin errors++; $display("[TB] FAIL rnd_fetch c=%0d fv=%0b fd=%h exp %0b/%h", c, fetch_valid, fetch_data, e_fv, e_fd); end
      checks++; if (data_valid !== e_dv || data_rdata !== e_dd) begin errors++; $display("[TB] FAIL rnd_data c=%0d dv=%0b rd=%h exp %0b/%h", c, data_valid, data_rdata, e_dv, e_dd); end
      checks++; if (bus_write_enable !== e_we) begin errors++; $display("[TB] FAIL rnd_we c=%0d got=%0b exp=%0b", c, bus_write_enable, e_we); end
      if (e_drive) begin
        checks++; if (bus_address !== e_addr) begin errors++; $display("[TB] FAIL rnd_addr c=%0d got=%h exp=%h", c, bus_address, e_addr); end
      end
      if (e_fr) f_pend = 0;
      if (e_dr) d_pend = 0;
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    mem[(`TEXT_BEGIN + 32'h10) >> 2] = 32'h00A0_0093;
    next_cycle();
    test_reset();
    test_fetch();
    test_store_load();
    test_tie();
    test_reset_in_read_wait();
    test_wait_in_read();
`ifdef EXAMPLE_BUS_ADDR_CHECK_EN
    test_addr_check();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/example_bus_arbiter.md
Name: example_bus_arbiter

Overview:
Arbiter directly upstream of the combined text/data memory bus in the multicycle RISC-V example. It accepts instruction-fetch reads and load/store accesses from the core over valid/ready handshakes and grants one at a time. It drives the single shared bus and holds address/read_enable across the memory's one-cycle synchronous read latency. It returns read data to the owning requester with a valid pulse.

Parameters:
FETCH_PRIORITY, 0, 0 = round-robin on simultaneous requests; 1 = fetch always wins ties

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
fetch_req  input  1  fetch request; held with fetch_addr until fetch_ready
fetch_addr  input  32  fetch byte address
fetch_ready  output  1  fetch request accepted this cycle
fetch_valid  output  1  fetch_data valid (one-cycle pulse)
fetch_data  output  32  fetched instruction word
fetch_error  output  1  fetch access faulted (optional feature; tied 0 otherwise)
data_req  input  1  load/store request; held with all data_* inputs until data_ready
data_we  input  1  1 = store, 0 = load
data_addr  input  32  load/store byte address
data_wdata  input  32  store data, lane-aligned
data_be  input  4  store byte enables
data_ready  output  1  data request accepted this cycle
data_valid  output  1  data_rdata valid (loads only, one-cycle pulse)
data_rdata  output  32  loaded word, unshifted
data_error  output  1  data access faulted (optional feature; tied 0 otherwise)
bus_address  output  32  to memory bus address
bus_write_data  output  32  to memory bus write_data
bus_byte_enable  output  4  to memory bus byte_enable
bus_read_enable  output  1  to memory bus read_enable
bus_write_enable  output  1  to memory bus write_enable
bus_read_data  input  32  from memory bus read_data

Behaviour:
- Clock and reset: single clock domain on clock; reset is synchronous and active-high.
- Reset: state=IDLE; last_grant=DATA, so fetch wins the first tie. All ready/valid/error outputs are 0, both bus enables are 0, bus_address/bus_write_data/bus_byte_enable are 0.
- FSM states: IDLE, READ_WAIT.
- IDLE, no requests: bus enables 0, bus_address 0.
- IDLE grant: if exactly one request, grant it. If both, FETCH_PRIORITY=1 grants fetch; otherwise grant the source that is not last_grant, then update last_grant.
- IDLE, grant is a load or fetch:
  - Bus driven combinationally from the granted request: bus_read_enable=1, bus_byte_enable=4'b1111.
  - The granted requester's ready=1.
  - Address latched into hold_addr; owner latched; go to READ_WAIT.
- IDLE, grant is a store:
  - bus_write_enable=1; bus_address/bus_write_data/bus_byte_enable come from the data_* inputs.
  - data_ready=1; stay in IDLE. No valid pulse is issued.
- READ_WAIT:
  - bus_address=hold_addr and bus_read_enable=1 are held, because the bus read mux is address-decoded. bus_write_enable=0.
  - The owner's valid=1 and its data=bus_read_data (combinational pass-through).
  - Both readys are 0; return to IDLE next cycle.
- Latency:
  - Read accepted in cycle N gives valid in N+1; next grant possible in N+2, so reads sustain 1 per 2 cycles.
  - Store accepted in cycle N writes at the cycle-N clock edge; next grant possible in N+1.
- Requests arriving during READ_WAIT wait; a pending request with no ready must remain stable.
- Non-owner valid is always 0. Data outputs carry 0 when their valid is 0.
- Reset asserted in READ_WAIT abandons the read: no valid pulse, IDLE next cycle.
- Low two address bits pass through unchanged; the memory ignores them. Alignment and sign extension belong to the core's LSU.

Optional Feature:
- Macro: EXAMPLE_BUS_ADDR_CHECK_EN.
- With macro:
  - Each granted address is decoded against `TEXT_BEGIN..`TEXT_END and `DATA_BEGIN..`DATA_END.
  - Faulting accesses: unmapped address, store to the text range, or fetch from the data range.
  - A faulting access is accepted normally (ready=1) but both bus enables stay 0.
  - A faulting read goes to READ_WAIT with bus_read_enable=0; the owner gets valid=1, data=0 and error=1.
  - A faulting store stays in IDLE; data_valid=1 and data_error=1 are pulsed in the next cycle.
- Without macro: no decode; fetch_error and data_error are constant 0; all accesses go to the bus.

Test Plan:
- Fetch `TEXT_BEGIN+0x10 alone, memory word 0x00A00093 -> fetch_ready in cycle N; bus_read_enable=1 and bus_address=`TEXT_BEGIN+0x10 in N and N+1; fetch_valid=1, fetch_data=0x00A00093 in N+1; data_valid=0 throughout.
- Store 0xDEADBEEF, be=4'b0011 to `DATA_BEGIN+4, then load the same address -> store bus_write_enable pulse 1 cycle; load returns 0x0000BEEF (prior contents 0); data_valid exactly one cycle.
- Fetch and load both requested for 6 cycles, FETCH_PRIORITY=0 -> grants alternate F,D,F (first tie to fetch); each completes 2 cycles apart. With FETCH_PRIORITY=1 -> fetch always granted, data_ready stays 0.
- Reset asserted in the READ_WAIT cycle of a load -> no data_valid; bus enables 0 and state IDLE the following cycle; the next request is granted normally.
- Load issued while fetch_req is raised in READ_WAIT -> fetch_ready=0 in READ_WAIT; fetch_addr held; fetch granted the cycle after.
- With EXAMPLE_BUS_ADDR_CHECK_EN: store to `TEXT_BEGIN, then load from 0x00000000 (unmapped) -> bus_write_enable stays 0 with data_error pulse next cycle; load gets data_valid=1, data_error=1, data_rdata=0, bus_read_enable=0.
